// File: rtl/uart_vip_xcvr_if.sv
// uart_vip_xcvr_if: byte streams between a UART transceiver and its host.
// master = host side, slave = transceiver side.
interface uart_vip_xcvr_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic [LW-1:0]        rx_level;

  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data, rx_level
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data, rx_level
  );
endinterface

// File: rtl/uart_vip_xcvr.sv
// uart_vip_xcvr: parametrised UART transceiver with RX FIFO and sticky errors.
// Define UART_VIP_PRINT_EN to echo received bytes and errors to the console.
module uart_vip_xcvr #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUDRATE   = 25000000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int LOOPBACK   = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic uart_rx,
  output logic uart_tx,
  uart_vip_xcvr_if.slave bus,
  output logic frame_err,
  output logic parity_err,
  output logic overrun,
  input  logic err_clr
);
  localparam int DIV  = CLK_HZ / BAUDRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;

  localparam logic [CW-1:0] TX_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] RX_BIT  = CW'(DIV);
  localparam logic [CW-1:0] RX_HALF = CW'(HALF);
  localparam logic [3:0]    D_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST  = 4'(STOP_BITS - 1);
  localparam logic          ODD     = (PARITY == 2);
  localparam logic          HAS_PAR = (PARITY != 0);
  localparam logic          LB      = (LOOPBACK != 0);

  if (DIV < 4 || (CLK_HZ % BAUDRATE) != 0) begin : g_bad_div
    $error("uart_vip_xcvr: CLK_HZ/BAUDRATE must be an integer >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
    $error("uart_vip_xcvr: unsupported frame format");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_fifo
    $error("uart_vip_xcvr: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic rx_s1, rx_s2, rx_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 fifo_vld, fifo_full;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign fifo_vld  = (level != '0);
  assign fifo_full = (level == LW'(FIFO_DEPTH));
  assign head      = mem[rd_ptr];

  logic                 src_valid;
  logic [DATA_BITS-1:0] src_data;

  // In loopback the FIFO head feeds the transmitter directly.
  assign src_valid = LB ? fifo_vld : bus.tx_valid;
  assign src_data  = LB ? head : bus.tx_data;

  state_t               tx_st, tx_st_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_par, tx_par_n;
  logic                 tx_armed;
  logic                 tx_end, tx_last, tx_rdy, tx_fire;

  assign tx_end  = (tx_cnt == TX_END);
  assign tx_last = (tx_st == S_STOP) && tx_end && (tx_bit == S_LAST);
  assign tx_rdy  = tx_armed && ((tx_st == S_IDLE) || tx_last);
  assign tx_fire = tx_rdy && src_valid;

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt + CW'(1);
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_par_n = tx_par;
    unique case (tx_st)
      S_IDLE: tx_cnt_n = '0;
      S_START: begin
        if (tx_end) begin
          tx_st_n  = S_DATA;
          tx_cnt_n = '0;
          tx_bit_n = '0;
        end
      end
      S_DATA: begin
        if (tx_end) begin
          tx_cnt_n = '0;
          tx_sh_n  = tx_sh >> 1;
          tx_bit_n = tx_bit + 4'd1;
          if (tx_bit == D_LAST) begin
            tx_bit_n = '0;
            tx_st_n  = HAS_PAR ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tx_end) begin
          tx_st_n  = S_STOP;
          tx_cnt_n = '0;
          tx_bit_n = '0;
        end
      end
      S_STOP: begin
        if (tx_end) begin
          tx_cnt_n = '0;
          tx_bit_n = tx_bit + 4'd1;
          if (tx_bit == S_LAST) tx_st_n = S_IDLE;
        end
      end
      default: tx_st_n = S_IDLE;
    endcase
    // A handshake on the last stop cycle chains straight into a start bit.
    if (tx_fire) begin
      tx_st_n  = S_START;
      tx_cnt_n = '0;
      tx_bit_n = '0;
      tx_sh_n  = src_data;
      tx_par_n = (^src_data) ^ ODD;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_st    <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_armed <= 1'b0;
    end else begin
      tx_st    <= tx_st_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx_armed <= 1'b1;
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    unique case (tx_st)
      S_START:  uart_tx = 1'b0;
      S_DATA:   uart_tx = tx_sh[0];
      S_PARITY: uart_tx = tx_par;
      default:  uart_tx = 1'b1;
    endcase
  end

  state_t               rx_st, rx_st_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [3:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_pbit, rx_pbit_n;
  logic                 rx_tick, rx_done;

  assign rx_tick = (rx_cnt == RX_BIT);
  assign rx_done = (rx_st == S_STOP) && rx_tick;

  // rx_cnt counts cycles since the last sample (or since the start edge).
  always_comb begin
    rx_st_n   = rx_st;
    rx_cnt_n  = rx_cnt + CW'(1);
    rx_bit_n  = rx_bit;
    rx_sh_n   = rx_sh;
    rx_pbit_n = rx_pbit;
    unique case (rx_st)
      S_IDLE: begin
        rx_cnt_n = CW'(1);
        if (rx_d && !rx_s2) rx_st_n = S_START;
      end
      S_START: begin
        if (rx_cnt == RX_HALF) begin
          rx_cnt_n = CW'(1);
          rx_bit_n = '0;
          rx_st_n  = rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_cnt_n = CW'(1);
          rx_sh_n  = {rx_s2, rx_sh[DATA_BITS-1:1]};
          rx_bit_n = rx_bit + 4'd1;
          if (rx_bit == D_LAST) rx_st_n = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rx_tick) begin
          rx_cnt_n  = CW'(1);
          rx_pbit_n = rx_s2;
          rx_st_n   = S_STOP;
        end
      end
      S_STOP: if (rx_tick) rx_st_n = S_IDLE;
      default: rx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_st   <= S_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_pbit <= 1'b0;
    end else begin
      rx_st   <= rx_st_n;
      rx_cnt  <= rx_cnt_n;
      rx_bit  <= rx_bit_n;
      rx_sh   <= rx_sh_n;
      rx_pbit <= rx_pbit_n;
    end
  end

  logic par_bad, ferr_ev, perr_ev, ovr_ev, good;

  assign par_bad = HAS_PAR && (rx_pbit != ((^rx_sh) ^ ODD));
  assign ferr_ev = rx_done && !rx_s2;
  assign perr_ev = rx_done && rx_s2 && par_bad;
  assign good    = rx_done && rx_s2 && !par_bad;
  assign pop     = fifo_vld && (LB ? tx_fire : bus.rx_ready);
  assign ovr_ev  = good && fifo_full && !pop;
  assign push    = good && !(fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_sh;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= ferr_ev | (frame_err  & ~err_clr);
      parity_err <= perr_ev | (parity_err & ~err_clr);
      overrun    <= ovr_ev  | (overrun    & ~err_clr);
    end
  end

  assign bus.tx_ready = tx_rdy;
  assign bus.rx_valid = fifo_vld;
  assign bus.rx_data  = fifo_vld ? head : '0;
  assign bus.rx_level = level;

`ifdef UART_VIP_PRINT_EN
  always_ff @(posedge clk) begin
    if (push)    $write("%c", rx_sh);
    if (ferr_ev) $display("[uart_vip] frame error @%0t", $time);
    if (perr_ev) $display("[uart_vip] parity error @%0t", $time);
  end
`else
`endif
endmodule

// File: tb/tb_uart_vip_xcvr.sv
// tb_uart_vip_xcvr: randomized checks of uart_vip_xcvr against a line model.
// Instances: 8N1 default, even parity, loopback.
module tb_uart_vip_xcvr;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRM   = 10 * DIV;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [2:0] rx_line;
  logic [2:0] tx_line;
  logic [2:0] ferr, perr, ovr;
  logic [2:0] clr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  logic       ovr_exp;

  always #5 clk = ~clk;

  uart_vip_xcvr_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) b0 ();
  uart_vip_xcvr_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) b1 ();
  uart_vip_xcvr_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) b2 ();

  uart_vip_xcvr u0 (
    .clk(clk), .resetn(resetn), .uart_rx(rx_line[0]), .uart_tx(tx_line[0]),
    .bus(b0), .frame_err(ferr[0]), .parity_err(perr[0]),
    .overrun(ovr[0]), .err_clr(clr[0])
  );

  uart_vip_xcvr #(.PARITY(1)) u1 (
    .clk(clk), .resetn(resetn), .uart_rx(rx_line[1]), .uart_tx(tx_line[1]),
    .bus(b1), .frame_err(ferr[1]), .parity_err(perr[1]),
    .overrun(ovr[1]), .err_clr(clr[1])
  );

  uart_vip_xcvr #(.LOOPBACK(1)) u2 (
    .clk(clk), .resetn(resetn), .uart_rx(rx_line[2]), .uart_tx(tx_line[2]),
    .bus(b2), .frame_err(ferr[2]), .parity_err(perr[2]),
    .overrun(ovr[2]), .err_clr(clr[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    int j;
    j = (k - 1) / DIV;
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    return 1'b1;
  endfunction

  task automatic send_frame(input int inst, input logic [7:0] d,
                            input bit has_par, input logic pbit,
                            input logic stop);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(pbit);
    bits.push_back(stop);
    foreach (bits[i]) begin
      rx_line[inst] = bits[i];
      cyc(DIV);
    end
    rx_line[inst] = 1'b1;
  endtask

  task automatic wait_ready;
    int w;
    w = 0;
    while (b0.tx_ready !== 1'b1 && w < 200) begin
      cyc(1);
      w++;
    end
    chk("tx_rdy_wait", b0.tx_ready, 1);
  endtask

  task automatic tx_stream(input int n, input logic [7:0] first);
    logic [7:0] cur;
    cur = first;
    wait_ready();
    b0.tx_valid = 1'b1;
    b0.tx_data  = cur;
    for (int i = 0; i < n; i++) begin
      for (int k = 1; k <= FRM; k++) begin
        cyc(1);
        chk("tx_bit", tx_line[0], frame_bit(cur, k));
        chk("tx_rdy", b0.tx_ready, k == FRM);
        if (k < FRM) begin
          b0.tx_data = 8'($urandom);
        end else if (i < n - 1) begin
          cur = 8'($urandom);
          b0.tx_data = cur;
        end else begin
          b0.tx_valid = 1'b0;
        end
      end
    end
    cyc(1);
    chk("tx_idle", tx_line[0], 1);
    chk("tx_rdy_idle", b0.tx_ready, 1);
  endtask

  task automatic pop0;
    b0.rx_ready = 1'b1;
    if (q.size() > 0) begin
      chk("pop_vld", b0.rx_valid, 1);
      chk("pop_data", b0.rx_data, q[0]);
      void'(q.pop_front());
    end
    cyc(1);
    b0.rx_ready = 1'b0;
    chk("pop_lvl", b0.rx_level, q.size());
  endtask

  task automatic rx0(input logic [7:0] d);
    send_frame(0, d, 1'b0, 1'b0, 1'b1);
    cyc(1);
    if (q.size() == DEPTH) ovr_exp = 1'b1;
    else q.push_back(d);
    chk("rx_lvl", b0.rx_level, q.size());
    chk("rx_ovr", ovr[0], ovr_exp);
  endtask

  task automatic clr_pulse(input int inst);
    clr[inst] = 1'b1;
    cyc(1);
    clr[inst] = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    rx_line = '1;
    clr = '0;
    ovr_exp = 1'b0;
    b0.tx_valid = 0; b0.tx_data = 0; b0.rx_ready = 0;
    b1.tx_valid = 0; b1.tx_data = 0; b1.rx_ready = 0;
    b2.tx_valid = 0; b2.tx_data = 0; b2.rx_ready = 0;

    #2 resetn = 1'b0;
    #1;
    chk("rst_tx", tx_line, 3'b111);
    chk("rst_rdy", b0.tx_ready, 0);
    chk("rst_vld", b0.rx_valid, 0);
    chk("rst_data", b0.rx_data, 0);
    chk("rst_lvl", b0.rx_level, 0);
    chk("rst_err", {ferr, perr, ovr}, 0);
    @(posedge clk);
    #1;
    cyc(2);
    resetn = 1'b1;
    chk("rel_rdy0", b0.tx_ready, 0);
    cyc(1);
    chk("rel_rdy1", {b2.tx_ready, b1.tx_ready, b0.tx_ready}, 3'b111);

    tx_stream(4, 8'h55);

    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    chk("a5_lat", b0.rx_valid, 0);
    cyc(1);
    q.push_back(8'hA5);
    chk("a5_vld", b0.rx_valid, 1);
    chk("a5_data", b0.rx_data, 8'hA5);
    chk("a5_lvl", b0.rx_level, 1);
    pop0();

    send_frame(0, 8'($urandom), 1'b0, 1'b0, 1'b0);
    clr[0] = 1'b1;
    cyc(1);
    clr[0] = 1'b0;
    chk("ferr_set", ferr[0], 1);
    chk("ferr_lvl", b0.rx_level, 0);
    clr_pulse(0);
    chk("ferr_clr", ferr[0], 0);
    cyc(4);

    rx_line[0] = 1'b0;
    cyc(1);
    rx_line[0] = 1'b1;
    cyc(20);
    chk("glitch_lvl", b0.rx_level, 0);
    chk("glitch_err", {ferr[0], perr[0], ovr[0]}, 0);

    for (int n = 0; n < 12; n++) begin
      cyc($urandom_range(0, 5));
      rx0(8'($urandom));
      repeat ($urandom_range(0, 2)) pop0();
    end
    while (q.size() > 0) pop0();
    clr_pulse(0);
    ovr_exp = 1'b0;
    chk("rand_ovr_clr", ovr[0], 0);

    for (int i = 0; i < 5; i++) rx0(8'(8'h10 + i));
    chk("full_lvl", b0.rx_level, DEPTH);
    chk("full_ovr", ovr[0], 1);
    clr_pulse(0);
    ovr_exp = 1'b0;
    chk("full_clr", ovr[0], 0);
    send_frame(0, 8'h15, 1'b0, 1'b0, 1'b1);
    b0.rx_ready = 1'b1;
    chk("pp_head", b0.rx_data, q[0]);
    void'(q.pop_front());
    q.push_back(8'h15);
    cyc(1);
    b0.rx_ready = 1'b0;
    chk("pp_lvl", b0.rx_level, DEPTH);
    chk("pp_ovr", ovr[0], 0);
    while (q.size() > 0) pop0();

    send_frame(1, 8'h01, 1'b1, 1'b0, 1'b1);
    cyc(1);
    chk("par_err", perr[1], 1);
    chk("par_lvl", b1.rx_level, 0);
    chk("par_ferr", ferr[1], 0);
    clr_pulse(1);
    chk("par_clr", perr[1], 0);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      send_frame(1, d, 1'b1, ^d, 1'b1);
      cyc(1);
      chk("par_ok_lvl", b1.rx_level, 1);
      chk("par_ok_data", b1.rx_data, d);
      chk("par_ok_err", perr[1], 0);
      b1.rx_ready = 1'b1;
      cyc(1);
      b1.rx_ready = 1'b0;
      d = 8'($urandom);
      send_frame(1, d, 1'b1, ~^d, 1'b1);
      cyc(1);
      chk("par_bad_err", perr[1], 1);
      chk("par_bad_lvl", b1.rx_level, 0);
      clr_pulse(1);
    end

    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 8'h3C : 8'($urandom);
      send_frame(2, d, 1'b0, 1'b0, 1'b1);
      chk("lb_pre", tx_line[2], 1);
      cyc(1);
      chk("lb_lvl1", b2.rx_level, 1);
      chk("lb_gap", tx_line[2], 1);
      for (int k = 1; k <= FRM; k++) begin
        cyc(1);
        chk("lb_bit", tx_line[2], frame_bit(d, k));
        if (k == 1) chk("lb_lvl0", b2.rx_level, 0);
      end
      cyc(2);
    end

    rx0(8'h77);
    wait_ready();
    b0.tx_valid = 1'b1;
    b0.tx_data  = 8'h00;
    cyc(1);
    b0.tx_valid = 1'b0;
    cyc(9);
    chk("mid_tx", tx_line[0], 0);
    #2 resetn = 1'b0;
    #1;
    q.delete();
    chk("mrst_tx", tx_line[0], 1);
    chk("mrst_rdy", b0.tx_ready, 0);
    chk("mrst_vld", b0.rx_valid, 0);
    chk("mrst_data", b0.rx_data, 0);
    chk("mrst_lvl", b0.rx_level, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("mrel_rdy0", b0.tx_ready, 0);
    cyc(1);
    chk("mrel_rdy1", b0.tx_ready, 1);
    cyc(2);
    chk("mrel_tx", tx_line[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_vip_xcvr.md
Name: uart_vip_xcvr

Overview:
- Parametrised, synthesizable UART transceiver used as the next-generation UART verification IP around the chip, and reusable as an on-chip UART core.
- Generalises the fixed 8N1 receive-only VIP:
  - configurable data width, parity and stop bits
  - a receive FIFO with a valid/ready interface
  - a transmit path
  - sticky error flags
  - an echo/loopback mode
- Instantiated beside the chip in the testbench; connects to chip UART pins.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- BAUDRATE, 25000000, line rate. DIV = CLK_HZ/BAUDRATE must be an integer >= 4; otherwise a $error is raised at elaboration.
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits (1 or 2).
- FIFO_DEPTH, 4, RX FIFO entries; power of two, >= 2.
- LOOPBACK, 0, 1 = every received byte is retransmitted; the tx_* inputs are ignored.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- uart_rx  in  1  serial input, idle high
- uart_tx  out  1  serial output, idle high
- tx_valid  in  1  transmit request
- tx_ready  out  1  transmitter idle and accepting a byte
- tx_data  in  DATA_BITS  byte to send
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  consumer pops the head when rx_valid is high
- rx_data  out  DATA_BITS  RX FIFO head
- rx_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- frame_err  out  1  sticky: stop bit sampled low
- parity_err  out  1  sticky: parity mismatch
- overrun  out  1  sticky: frame received while the FIFO was full
- err_clr  in  1  synchronous clear of all sticky flags

Behaviour:
- Reset (async, resetn=0) forces the following immediately, including mid-frame:
  - uart_tx=1, tx_ready=0, rx_valid=0, rx_data=0, rx_level=0
  - all error flags 0; both FSMs to IDLE; FIFO emptied.
  - On the first clk edge after reset release, tx_ready=1.
- Sync: uart_rx passes through a 2-flop synchroniser reset to 1. All RX timing below is relative to the synchronised signal.
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - Handshake completes on a cycle where tx_valid && tx_ready. tx_data is latched, tx_ready drops next cycle, and uart_tx goes low that same next cycle.
  - Each bit lasts exactly DIV cycles. Data is sent LSB first, then the parity bit if PARITY != 0, then STOP_BITS high bits.
  - tx_ready returns to 1 on the last cycle of the final stop bit. A handshake on that cycle starts the next start bit with no idle gap.
  - Total frame = DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- RX FSM, states IDLE, START, DATA, PARITY, STOP:
  - In IDLE, a falling edge at cycle t enters START.
  - The start bit is sampled at t+DIV/2. If it reads high, the event is a glitch: return to IDLE and record nothing.
  - Data bit i is sampled at t+DIV/2+(i+1)*DIV. Parity and stop bits follow at the same spacing.
  - Only the first stop bit is checked.
  - After the stop-bit sample, return to IDLE in the same cycle so the next start edge can be detected immediately.
- Frame result, decided at the stop-bit sample:
  - Stop low: frame_err=1, byte discarded.
  - Parity mismatch: parity_err=1, byte discarded.
  - FIFO full: overrun=1, byte discarded, FIFO contents untouched.
  - Otherwise the byte is pushed; rx_valid/rx_level update on the next cycle.
- FIFO:
  - Pop occurs when rx_valid && rx_ready.
  - A simultaneous push and pop leaves rx_level unchanged, including when the FIFO is full (the pop makes room, so no overrun).
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Errors: flags are sticky. If err_clr is asserted on the same cycle as a new error event, the set wins.
- LOOPBACK=1:
  - The TX source is the FIFO head: the TX handshake pops the FIFO. tx_valid and tx_data are ignored.
  - rx_valid still reflects FIFO state; rx_ready is ignored.

Optional Feature:
- Macro: UART_VIP_PRINT_EN.
- Defined: each accepted RX byte is printed with $write("%c") at push time. frame_err and parity_err events print "[uart_vip] frame error @%0t" or "[uart_vip] parity error @%0t".
- Undefined: no simulation output and no non-synthesizable constructs; all other behaviour is identical.

Test Plan:
- Defaults (DIV=4, 8N1). Handshake tx_data=0x55 at cycle c:
  - uart_tx is low during c+1..c+4, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high during c+37..c+40.
  - tx_ready is high again at c+40.
- Defaults. Drive frame 0xA5 on uart_rx:
  - rx_valid=1 one cycle after the stop sample, with rx_data=0xA5 and rx_level=1.
  - Pulsing rx_ready for 1 cycle gives rx_level=0.
- PARITY=1. Drive 0x01 with parity bit 0:
  - parity_err=1, rx_level stays 0.
  - err_clr for 1 cycle clears parity_err.
- FIFO_DEPTH=4, rx_ready=0. Send 0x10,0x11,0x12,0x13,0x14:
  - rx_level=4, overrun=1.
  - Popping returns 0x10..0x13 in order.
- Defaults. A 1-cycle low glitch on uart_rx gives no push and no error flag. Asserting resetn=0 mid-TX drives uart_tx=1 and tx_ready=0 immediately.
- LOOPBACK=1. Drive 0x3C on uart_rx:
  - An identical 0x3C frame appears on uart_tx, starting 2 cycles after the stop sample.
  - rx_level returns to 0.
